// File: rtl/fixed_point_addsub_pipe.sv
// Two-stage pipelined fixed-point adder/subtractor with valid/ready on both sides.
// Operands are {signed integer, unsigned fraction} concatenations. Arithmetic runs on
// the full concatenation, so any carry or borrow between the fraction and integer
// parts happens automatically.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds valid and its data until that edge. The consumer may change
// ready at any time. This block never drops valid, and never changes the result,
// while out_valid && !out_ready.
module fixed_point_addsub_pipe #(
  parameter int INTEGER_WIDTH = 8,
  parameter int DECIMAL_WIDTH = 23,
  parameter bit SATURATE      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op_sub,
  input  logic [INTEGER_WIDTH-1:0] float_a_integer,
  input  logic [DECIMAL_WIDTH-1:0] float_a_decimal,
  input  logic [INTEGER_WIDTH-1:0] float_b_integer,
  input  logic [DECIMAL_WIDTH-1:0] float_b_decimal,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INTEGER_WIDTH-1:0] result_integer,
  output logic [DECIMAL_WIDTH-1:0] result_decimal,
  output logic                     overflow
);

  localparam int W = INTEGER_WIDTH + DECIMAL_WIDTH;

  // The whole pipe advances together; it stalls only when a result is waiting
  // on the consumer. Bubbles are not squeezed out.
  logic en;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Sign-extend both operands by one bit so the sum or difference is exact.
  logic [W:0] a_ext;
  logic [W:0] b_ext;
  logic [W:0] sum_next;
  assign a_ext    = {float_a_integer[INTEGER_WIDTH-1], float_a_integer, float_a_decimal};
  assign b_ext    = {float_b_integer[INTEGER_WIDTH-1], float_b_integer, float_b_decimal};
  assign sum_next = op_sub ? (a_ext - b_ext) : (a_ext + b_ext);

  logic       s1_valid;
  logic [W:0] s1_sum;

  // Stage 1: capture the exact W+1-bit sum together with its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sum   <= sum_next;
    end
  end

  // The result overflows when the extra sign bit disagrees with the W-bit sign bit.
  logic         s1_ovf;
  logic [W-1:0] s1_res;
  logic [W-1:0] sat_max;
  logic [W-1:0] sat_min;
  assign sat_max = {1'b0, {(W-1){1'b1}}};
  assign sat_min = {1'b1, {(W-1){1'b0}}};
  assign s1_ovf  = s1_sum[W] ^ s1_sum[W-1];

  // Overflow handling: clamp toward the sign of the true result, or wrap to W bits.
  always_comb begin
    s1_res = s1_sum[W-1:0];
    if (SATURATE && s1_ovf) begin
      s1_res = s1_sum[W] ? sat_min : sat_max;
    end
  end

  // Stage 2: register the final result, the overflow flag and out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      overflow       <= 1'b0;
      result_integer <= '0;
      result_decimal <= '0;
    end else if (en) begin
      out_valid      <= s1_valid;
      overflow       <= s1_ovf;
      result_integer <= s1_res[W-1:DECIMAL_WIDTH];
      result_decimal <= s1_res[DECIMAL_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Bench for fixed_point_addsub_pipe. It runs a saturating and a wrapping instance
// side by side, driven by the same inputs.
module tb_fixed_point_addsub_pipe;

  localparam int IW = 8;
  localparam int DW = 23;
  localparam int W  = IW + DW;
  localparam int EW = 2 * W + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          op_sub = 1'b0;
  logic          out_ready = 1'b0;
  logic [IW-1:0] a_int = '0;
  logic [DW-1:0] a_dec = '0;
  logic [IW-1:0] b_int = '0;
  logic [DW-1:0] b_dec = '0;

  logic          in_ready, out_valid, overflow;
  logic [IW-1:0] result_integer;
  logic [DW-1:0] result_decimal;
  logic          in_ready_w, out_valid_w, overflow_w;
  logic [IW-1:0] result_integer_w;
  logic [DW-1:0] result_decimal_w;

  fixed_point_addsub_pipe #(.INTEGER_WIDTH(IW), .DECIMAL_WIDTH(DW), .SATURATE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .float_a_integer(a_int), .float_a_decimal(a_dec),
    .float_b_integer(b_int), .float_b_decimal(b_dec),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_integer(result_integer), .result_decimal(result_decimal), .overflow(overflow)
  );

  fixed_point_addsub_pipe #(.INTEGER_WIDTH(IW), .DECIMAL_WIDTH(DW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .op_sub(op_sub),
    .float_a_integer(a_int), .float_a_decimal(a_dec),
    .float_b_integer(b_int), .float_b_decimal(b_dec),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .result_integer(result_integer_w), .result_decimal(result_decimal_w), .overflow(overflow_w)
  );

  int checks   = 0;
  int failures = 0;
  int acc_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model on real-valued scaled integers: value = integer*2^DW + fraction.
  function automatic logic [EW-1:0] model(input logic [IW-1:0] ai, input logic [DW-1:0] ad,
                                          input logic [IW-1:0] bi, input logic [DW-1:0] bd,
                                          input logic sub);
    longint va, vb, s, maxv, minv, sv;
    logic [W-1:0] sat_b, wrap_b;
    logic o;
    va   = longint'($signed(ai)) * (longint'(1) <<< DW) + longint'(ad);
    vb   = longint'($signed(bi)) * (longint'(1) <<< DW) + longint'(bd);
    s    = sub ? (va - vb) : (va + vb);
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -(longint'(1) <<< (W - 1));
    o    = (s > maxv) || (s < minv);
    sv   = (s > maxv) ? maxv : ((s < minv) ? minv : s);
    sat_b  = sv[W-1:0];
    wrap_b = s[W-1:0];
    return {o, sat_b, wrap_b};
  endfunction

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic          hold_pend = 1'b0;
  logic [IW-1:0] h_int, h_int_w;
  logic [DW-1:0] h_dec, h_dec_w;
  logic          h_ovf, h_ovf_w;

  // Compare process: handshakes are evaluated mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_int", result_integer, h_int);
        chk("hold_dec", result_decimal, h_dec);
        chk("hold_ovf", overflow, h_ovf);
        chk("hold_int_w", result_integer_w, h_int_w);
        chk("hold_dec_w", result_decimal_w, h_dec_w);
        chk("hold_ovf_w", overflow_w, h_ovf_w);
      end
      chk("valid_pair", out_valid_w, out_valid);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_result actual=out_valid expected=no_result at %0t", $time);
        end else begin
          logic [EW-1:0] e;
          logic [W-1:0] es, ew;
          e  = exp_q.pop_front();
          es = e[2*W-1:W];
          ew = e[W-1:0];
          chk("sb_sat_int", result_integer, es[W-1:DW]);
          chk("sb_sat_dec", result_decimal, es[DW-1:0]);
          chk("sb_sat_ovf", overflow, e[EW-1]);
          chk("sb_wrap_int", result_integer_w, ew[W-1:DW]);
          chk("sb_wrap_dec", result_decimal_w, ew[DW-1:0]);
          chk("sb_wrap_ovf", overflow_w, e[EW-1]);
        end
      end
      hold_pend = out_valid && !out_ready;
      h_int = result_integer;   h_dec = result_decimal;   h_ovf = overflow;
      h_int_w = result_integer_w; h_dec_w = result_decimal_w; h_ovf_w = overflow_w;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_int, a_dec, b_int, b_dec, op_sub));
        acc_count++;
      end
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic set_op(input logic [IW-1:0] ai, input logic [DW-1:0] ad,
                        input logic [IW-1:0] bi, input logic [DW-1:0] bd, input logic sub);
    a_int = ai; a_dec = ad; b_int = bi; b_dec = bd; op_sub = sub; in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // One op with literal expectations, including the two-cycle latency.
  task automatic directed(input string name,
                          input logic [IW-1:0] ai, input logic [DW-1:0] ad,
                          input logic [IW-1:0] bi, input logic [DW-1:0] bd, input logic sub,
                          input logic [IW-1:0] ei, input logic [DW-1:0] ed, input logic eo,
                          input logic [IW-1:0] wi, input logic [DW-1:0] wd);
    int n;
    logic found;
    out_ready = 1'b1;
    set_op(ai, ad, bi, bd, sub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) found = 1'b1;
    end
    chk({name, "_latency"}, n, 2);
    chk({name, "_int"}, result_integer, ei);
    chk({name, "_dec"}, result_decimal, ed);
    chk({name, "_ovf"}, overflow, eo);
    chk({name, "_wint"}, result_integer_w, wi);
    chk({name, "_wdec"}, result_decimal_w, wd);
    chk({name, "_wovf"}, overflow_w, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    int iter;

    // reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_int", result_integer, 0);
    chk("rst_dec", result_decimal, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // directed literal vectors
    directed("basic_add", 8'd4, 23'd1, 8'd2, 23'd1, 1'b0, 8'd6, 23'd2, 1'b0, 8'd6, 23'd2);
    directed("frac_carry", 8'd1, 23'h7FFFFF, 8'd0, 23'd1, 1'b0, 8'd2, 23'd0, 1'b0, 8'd2, 23'd0);
    directed("frac_borrow", 8'd4, 23'd0, 8'd2, 23'd1, 1'b1, 8'd1, 23'h7FFFFF, 1'b0, 8'd1, 23'h7FFFFF);
    directed("sub_neg", 8'd2, 23'd0, 8'd4, 23'd0, 1'b1, 8'hFE, 23'd0, 1'b0, 8'hFE, 23'd0);
    directed("a_minus_a", 8'd5, 23'h123456, 8'd5, 23'h123456, 1'b1, 8'd0, 23'd0, 1'b0, 8'd0, 23'd0);
    directed("pos_ovf", 8'd127, 23'h400000, 8'd1, 23'd0, 1'b0, 8'd127, 23'h7FFFFF, 1'b1, 8'h80, 23'h400000);
    directed("neg_ovf", 8'h80, 23'd0, 8'd0, 23'd1, 1'b1, 8'h80, 23'd0, 1'b1, 8'd127, 23'h7FFFFF);
    directed("max_plus_0", 8'd127, 23'h7FFFFF, 8'd0, 23'd0, 1'b0, 8'd127, 23'h7FFFFF, 1'b0, 8'd127, 23'h7FFFFF);

    // backpressure: two accepts, then the pipe stalls with held outputs
    out_ready = 1'b0;
    base = acc_count;
    set_op(8'd10, 23'd5, 8'd3, 23'd7, 1'b0);
    @(posedge clk); #1;
    set_op(8'd20, 23'd0, 8'd30, 23'd1, 1'b1);
    @(posedge clk); #1;
    set_op(8'hF0, 23'h1FFFFF, 8'd7, 23'h600000, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_accepts", acc_count - base, 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept("bp_op3");
    set_op(8'd100, 23'h0ABCDE, 8'd50, 23'h7FFFFF, 1'b0);
    wait_accept("bp_op4");
    drain("bp");
    chk("bp_total", acc_count - base, 4);

    // reset mid-operation: the two accepted ops must never come out
    out_ready = 1'b0;
    set_op(8'd33, 23'd3, 8'd44, 23'd4, 1'b0);
    @(posedge clk); #1;
    set_op(8'd55, 23'd5, 8'd66, 23'd6, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_int", result_integer, 0);
    chk("mid_rst_dec", result_decimal, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // random traffic with random consumer stalls
    base = acc_count;
    iter = 0;
    while ((acc_count - base) < 1000 && iter < 20000) begin
      logic [IW-1:0] ri;
      logic [DW-1:0] rd;
      if (!in_valid || in_ready) begin
        ri = 8'($urandom_range(0, 255));
        rd = 23'($urandom());
        if ($urandom_range(0, 9) == 0) rd = 23'h7FFFFF;
        set_op(ri, rd, 8'($urandom_range(0, 255)), 23'($urandom()), 1'($urandom_range(0, 1)));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      iter++;
    end
    in_valid = 1'b0;
    chk("rand_count", (acc_count - base) >= 1000, 1);
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
